// File: rtl/display_bbox_pkg.sv
// Shared definitions for the display bounding-box sender.
//   BBOX_INVALID : word the overlay treats as "no box in this slot"
//   *_HI/*_LO    : bit ranges of the four 16-bit fields in a box word
//   state_t      : sender FSM states
package display_bbox_pkg;

  localparam logic [63:0] BBOX_INVALID = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int X0_HI = 63;
  localparam int X0_LO = 48;
  localparam int Y0_HI = 47;
  localparam int Y0_LO = 32;
  localparam int X1_HI = 31;
  localparam int X1_LO = 16;
  localparam int Y1_HI = 15;
  localparam int Y1_LO = 0;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/display_bbox_sanitize.sv
// Combinational clean-up of one detection before it is stored.
//   det : raw detection {x0, y0, x1, y1}
//   san : BBOX_INVALID when the top-left corner is off-screen or the box is
//         inverted, otherwise the box with x1/y1 clamped to the frame edge.
module display_bbox_sanitize
  import display_bbox_pkg::*;
#(
  parameter int FRAME_WIDTH  = 16,
  parameter int FRAME_HEIGHT = 9
) (
  input  logic [63:0] det,
  output logic [63:0] san
);

  localparam logic [15:0] X_MAX = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(FRAME_HEIGHT - 1);

  logic [15:0] x0, y0, x1, y1;
  logic        bad;

  assign x0  = det[X0_HI:X0_LO];
  assign y0  = det[Y0_HI:Y0_LO];
  assign x1  = det[X1_HI:X1_LO];
  assign y1  = det[Y1_HI:Y1_LO];
  assign bad = (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1) || (y0 > y1);

  always_comb begin
    san = BBOX_INVALID;
    if (!bad)
      san = {x0, y0, (x1 > X_MAX) ? X_MAX : x1, (y1 > Y_MAX) ? Y_MAX : y1};
  end

endmodule

// File: rtl/display_bbox_sender.sv
// Producer side of the display bounding-box interface.
// Collects sanitised detections into one bank while the other bank holds the
// last committed set, and emits a committed set as exactly MAX_BBOX contiguous
// words starting the cycle after a frame_start.
//   clk, rst            : clock, async active-high reset
//   det_data/valid/last : detection stream in (det_last commits the set)
//   det_ready           : low while a committed set awaits its frame
//   frame_start         : frame boundary pulse
//   bbox_data_out(_valid): registered box words to the overlay
//   bbox_pending        : committed set waiting for frame_start
//   det_overflow        : pulse after a set that carried > MAX_BBOX beats
// Optional: `define DISPLAY_BBOX_STALE_CLEAR_EN sends one all-invalid burst
// after STALE_FRAMES frames without a new set.
module display_bbox_sender
  import display_bbox_pkg::*;
#(
  parameter int FRAME_WIDTH  = 16,
  parameter int FRAME_HEIGHT = 9,
  parameter int MAX_BBOX     = 5,
  parameter int STALE_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] det_data,
  input  logic        det_valid,
  input  logic        det_last,
  output logic        det_ready,
  input  logic        frame_start,
  output logic [63:0] bbox_data_out,
  output logic        bbox_data_out_valid,
  output logic        bbox_pending,
  output logic        det_overflow
);

  localparam int CW = $clog2(MAX_BBOX + 1);
  localparam int IW = (MAX_BBOX > 1) ? $clog2(MAX_BBOX) : 1;

  logic [63:0]   bank [2][MAX_BBOX];
  logic          col_sel;   // bank being collected; ~col_sel is the send bank
  logic          pending;
  logic          ovf;
  logic [CW-1:0] cnt;
  logic [63:0]   san;
  logic          accept;

  state_t        state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [63:0]   nxt_data;
  logic          nxt_valid;
  logic          swap;

  assign det_ready    = !pending;
  assign bbox_pending = pending;
  assign accept       = det_valid & det_ready;

  display_bbox_sanitize #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_sanitize (
    .det(det_data),
    .san(san)
  );

`ifdef DISPLAY_BBOX_STALE_CLEAR_EN
  localparam int FW = $clog2(STALE_FRAMES + 2);
  logic [FW-1:0] frame_cnt;
  logic          clr_burst, clr, stale_hit;

  assign stale_hit = (frame_cnt == FW'(STALE_FRAMES)) && !pending;

  // Counter saturates one past the threshold so only one clear is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      clr_burst <= 1'b0;
    end else begin
      if (swap)
        frame_cnt <= '0;
      else if (frame_start && frame_cnt != FW'(STALE_FRAMES + 1))
        frame_cnt <= frame_cnt + FW'(1);
      clr_burst <= clr | (clr_burst & (nxt_state == SEND));
    end
  end
`endif

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_data  = '0;
    nxt_valid = 1'b0;
    swap      = 1'b0;
`ifdef DISPLAY_BBOX_STALE_CLEAR_EN
    clr       = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Word 0 is registered on the swap edge itself; the collect bank
        // becomes the send bank at that same edge.
        if (frame_start && pending) begin
          swap      = 1'b1;
          nxt_data  = bank[col_sel][0];
          nxt_valid = 1'b1;
          nxt_idx   = IW'(1);
          nxt_state = (MAX_BBOX > 1) ? SEND : IDLE;
        end
`ifdef DISPLAY_BBOX_STALE_CLEAR_EN
        else if (frame_start && stale_hit) begin
          clr       = 1'b1;
          nxt_data  = BBOX_INVALID;
          nxt_valid = 1'b1;
          nxt_idx   = IW'(1);
          nxt_state = (MAX_BBOX > 1) ? SEND : IDLE;
        end
`endif
      end
      SEND: begin
        nxt_valid = 1'b1;
`ifdef DISPLAY_BBOX_STALE_CLEAR_EN
        nxt_data  = clr_burst ? BBOX_INVALID : bank[~col_sel][idx];
`else
        nxt_data  = bank[~col_sel][idx];
`endif
        nxt_idx   = idx + IW'(1);
        if (idx == IW'(MAX_BBOX - 1))
          nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      idx                 <= '0;
      bbox_data_out       <= '0;
      bbox_data_out_valid <= 1'b0;
      pending             <= 1'b0;
      cnt                 <= '0;
      ovf                 <= 1'b0;
      det_overflow        <= 1'b0;
      col_sel             <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MAX_BBOX; i++)
          bank[b][i] <= BBOX_INVALID;
    end else begin
      state               <= nxt_state;
      idx                 <= nxt_idx;
      bbox_data_out       <= nxt_data;
      bbox_data_out_valid <= nxt_valid;
      det_overflow        <= 1'b0;

      // Swap and accept are exclusive: accept needs pending=0, swap needs 1.
      if (swap) begin
        col_sel <= ~col_sel;
        pending <= 1'b0;
        for (int i = 0; i < MAX_BBOX; i++)
          bank[~col_sel][i] <= BBOX_INVALID;
      end

      if (accept) begin
        if (cnt < CW'(MAX_BBOX))
          bank[col_sel][cnt[IW-1:0]] <= san;
        if (det_last) begin
          pending      <= 1'b1;
          cnt          <= '0;
          ovf          <= 1'b0;
          det_overflow <= ovf | (cnt == CW'(MAX_BBOX));
        end else if (cnt < CW'(MAX_BBOX)) begin
          cnt <= cnt + CW'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_bbox_sender.sv
module tb_display_bbox_sender;
  import display_bbox_pkg::*;

  localparam int MB = 5;
  localparam logic [63:0] INV = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] det_data;
  logic        det_valid, det_last, det_ready, frame_start;
  logic [63:0] bbox_data_out;
  logic        bbox_data_out_valid, bbox_pending, det_overflow;

  display_bbox_sender #(
    .FRAME_WIDTH (16),
    .FRAME_HEIGHT(9),
    .MAX_BBOX    (MB),
    .STALE_FRAMES(3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .det_data           (det_data),
    .det_valid          (det_valid),
    .det_last           (det_last),
    .det_ready          (det_ready),
    .frame_start        (frame_start),
    .bbox_data_out      (bbox_data_out),
    .bbox_data_out_valid(bbox_data_out_valid),
    .bbox_pending       (bbox_pending),
    .det_overflow       (det_overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] exp_w [MB];

  typedef struct packed {
    logic [63:0] det;
    logic [63:0] exp;
  } vec_t;
  vec_t vt [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    det_valid = 1'b1;
    det_data  = d;
    det_last  = last;
    chk("det_ready before beat", 64'(det_ready), 64'd1);
    step();
    det_valid = 1'b0;
    det_last  = 1'b0;
  endtask

  // frame_start, then MB words expected back-to-back, then valid low.
  task automatic burst(input string nm);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < MB; k++) begin
      chk($sformatf("%s valid w%0d", nm, k), 64'(bbox_data_out_valid), 64'd1);
      chk($sformatf("%s data w%0d", nm, k), bbox_data_out, exp_w[k]);
      if (k < MB - 1) step();
    end
    step();
    chk($sformatf("%s valid after", nm), 64'(bbox_data_out_valid), 64'd0);
  endtask

  initial begin
    vt[0] = '{64'h0001_0001_0004_0003, 64'h0001_0001_0004_0003};
    vt[1] = '{64'h0002_0002_0014_000C, 64'h0002_0002_000F_0008};
    vt[2] = '{64'h0010_0000_0012_0004, INV};
    vt[3] = '{64'h0005_0001_0003_0002, INV};
    vt[4] = '{64'h0000_0008_0000_0008, 64'h0000_0008_0000_0008};
    vt[5] = '{64'h0000_0009_0000_0009, INV};
    vt[6] = '{64'h000F_0000_000F_0000, 64'h000F_0000_000F_0000};
    vt[7] = '{64'h0003_0004_0003_0003, INV};
    vt[8] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_000F_0008};

    rst = 1'b1; det_data = '0; det_valid = 1'b0; det_last = 1'b0; frame_start = 1'b0;
    #12;
    chk("reset data", bbox_data_out, 64'd0);
    chk("reset valid", 64'(bbox_data_out_valid), 64'd0);
    chk("reset pending", 64'(bbox_pending), 64'd0);
    chk("reset overflow", 64'(det_overflow), 64'd0);
    chk("reset ready", 64'(det_ready), 64'd1);
    rst = 1'b0;
    step();

    // Two-beat set from the plan.
    beat(64'h0001_0001_0004_0003, 1'b0);
    beat(64'h0002_0002_0014_000C, 1'b1);
    chk("pending after commit", 64'(bbox_pending), 64'd1);
    chk("ready after commit", 64'(det_ready), 64'd0);
    exp_w[0] = 64'h0001_0001_0004_0003;
    exp_w[1] = 64'h0002_0002_000F_0008;
    for (int k = 2; k < MB; k++) exp_w[k] = INV;
    burst("two_beat");

    // Single-beat (empty) sets through the sanitiser.
    for (int v = 0; v < 9; v++) begin
      beat(vt[v].det, 1'b1);
      exp_w[0] = vt[v].exp;
      for (int k = 1; k < MB; k++) exp_w[k] = INV;
      burst($sformatf("vec%0d", v));
    end

    // Overflow: 7 beats, first 5 kept, one pulse.
    for (int i = 0; i < 7; i++) begin
      beat({16'(i), 16'd0, 16'(i + 1), 16'd1}, i == 6);
      chk($sformatf("overflow pulse after beat %0d", i), 64'(det_overflow), (i == 6) ? 64'd1 : 64'd0);
    end
    step();
    chk("overflow pulse width", 64'(det_overflow), 64'd0);
    for (int k = 0; k < MB; k++) exp_w[k] = {16'(k), 16'd0, 16'(k + 1), 16'd1};
    burst("overflow");

    // Commit on the same edge as frame_start: not sent this frame.
    det_valid = 1'b1; det_data = 64'h0004_0004_0006_0006; det_last = 1'b1; frame_start = 1'b1;
    step();
    det_valid = 1'b0; det_last = 1'b0; frame_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("same-edge no burst", 64'(bbox_data_out_valid), 64'd0);
      chk("same-edge ready low", 64'(det_ready), 64'd0);
      step();
    end
    exp_w[0] = 64'h0004_0004_0006_0006;
    for (int k = 1; k < MB; k++) exp_w[k] = INV;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("ready back after swap", 64'(det_ready), 64'd1);
    chk("same-edge w0", bbox_data_out, exp_w[0]);
    for (int k = 1; k < MB; k++) begin
      step();
      chk("same-edge wN", bbox_data_out, exp_w[k]);
    end
    step();
    chk("same-edge valid after", 64'(bbox_data_out_valid), 64'd0);

    // frame_start with nothing pending.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("idle frame no valid", 64'(bbox_data_out_valid), 64'd0);
      step();
    end

    // Burst A, commit B during it, frame_start at T+2 ignored.
    beat(64'h0001_0002_0003_0004, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("midA w0", bbox_data_out, 64'h0001_0002_0003_0004);
    det_valid = 1'b1; det_data = 64'h0007_0000_0008_0001; det_last = 1'b1;
    step();
    det_valid = 1'b0; det_last = 1'b0; frame_start = 1'b1;
    chk("midA w1", bbox_data_out, INV);
    step();
    frame_start = 1'b0;
    chk("midA pending B", 64'(bbox_pending), 64'd1);
    for (int k = 2; k < MB; k++) begin
      chk("midA valid", 64'(bbox_data_out_valid), 64'd1);
      chk("midA wN", bbox_data_out, INV);
      step();
    end
    chk("midA no restart", 64'(bbox_data_out_valid), 64'd0);
    step();
    chk("midA still idle", 64'(bbox_data_out_valid), 64'd0);
    exp_w[0] = 64'h0007_0000_0008_0001;
    for (int k = 1; k < MB; k++) exp_w[k] = INV;
    burst("setB");

    // Reset in the middle of a burst.
    beat(64'h0002_0002_0003_0003, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    chk("pre-reset valid", 64'(bbox_data_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset abort valid", 64'(bbox_data_out_valid), 64'd0);
    chk("reset abort data", bbox_data_out, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post-reset valid", 64'(bbox_data_out_valid), 64'd0);
    chk("post-reset ready", 64'(det_ready), 64'd1);

`ifdef DISPLAY_BBOX_STALE_CLEAR_EN
    beat(64'h0001_0001_0002_0002, 1'b1);
    exp_w[0] = 64'h0001_0001_0002_0002;
    for (int k = 1; k < MB; k++) exp_w[k] = INV;
    burst("stale_set");
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("stale quiet", 64'(bbox_data_out_valid), 64'd0);
      step();
    end
    for (int k = 0; k < MB; k++) exp_w[k] = INV;
    burst("stale_clear");
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("stale no repeat", 64'(bbox_data_out_valid), 64'd0);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
